regfile_wb_ctrl: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_ctrl_if.sv | 26 ++
 rtl/regfile_wb_ctrl_rr_arbiter.sv | 53 +++++
 rtl/regfile_wb_ctrl.sv | 91 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file write-back path.
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back requester bus: per-requester valid/idx/data with a ready grant back.
interface regfile_wb_ctrl_if #(
    parameter int NUM_REQ = 2
) ();
    import regfile_pkg::*;

    logic     [NUM_REQ-1:0] req_valid_i;
    reg_idx_t [NUM_REQ-1:0] req_idx_i;
    xlen_t    [NUM_REQ-1:0] req_data_i;
    logic     [NUM_REQ-1:0] req_ready_o;

    modport master (
        output req_valid_i,
        output req_idx_i,
        output req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_idx_i,
        input  req_data_i,
        output req_ready_o
    );

endinterface

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] cand;
    logic             found;
    int               pos;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        cand    = '0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = PTR_W'(pos);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
            end
        end
    end

    // Kept apart from the grant search so the advance strobe derived from grant_o forms no block-level loop.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (advance_i && grant_o[i]) begin
                ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates requesters onto the registered register-file write port
// and tracks in-flight destinations in a busy bitmap for hazard stalls.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    regfile_wb_ctrl_if.slave   wb,
    output logic               wr_en_o,
    output reg_idx_t           rd_idx_o,
    output xlen_t              rd_data_o,
    input  logic               alloc_valid_i,
    input  reg_idx_t           alloc_idx_i,
    output logic               alloc_busy_o,
    input  reg_idx_t           rs1_idx_i,
    input  reg_idx_t           rs2_idx_i,
    output logic               rs1_busy_o,
    output logic               rs2_busy_o
);

    logic [NUM_REQ-1:0]  grant;
    logic                xfer;
    reg_idx_t            sel_idx;
    xlen_t               sel_data;

    logic                wr_en_q, wr_en_d;
    reg_idx_t            rd_idx_q, rd_idx_d;
    xlen_t               rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (wb.req_valid_i),
        .advance_i (xfer),
        .grant_o   (grant)
    );

    assign wb.req_ready_o = grant;
    assign xfer           = |(grant & wb.req_valid_i);

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = wb.req_idx_i[i];
                sel_data = wb.req_data_i[i];
            end
        end
    end

    // A grant to x0 is consumed and still latched, but never raises the write enable.
    always_comb begin
        wr_en_d   = xfer && (sel_idx != '0);
        rd_idx_d  = xfer ? sel_idx  : rd_idx_q;
        rd_data_d = xfer ? sel_data : rd_data_q;
    end

    // Clear applies first so a same-index alloc on the commit edge keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) busy_d[rd_idx_q] = 1'b0;
        if (alloc_valid_i && (alloc_idx_i != '0)) busy_d[alloc_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign rd_idx_o     = rd_idx_q;
    assign rd_data_o    = rd_data_q;
    assign alloc_busy_o = (alloc_idx_i != '0) && busy_q[alloc_idx_i];
    assign rs1_busy_o   = (rs1_idx_i   != '0) && busy_q[rs1_idx_i];
    assign rs2_busy_o   = (rs2_idx_i   != '0) && busy_q[rs2_idx_i];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by random traffic
// compared against a cycle-level behavioural model of the write-back rules.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    localparam int N = 2;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     alloc_valid;
    reg_idx_t alloc_idx, rs1_idx, rs2_idx;
    logic     wr_en, alloc_busy, rs1_busy, rs2_busy;
    reg_idx_t rd_idx;
    xlen_t    rd_data;

    always #5 clk = ~clk;

    regfile_wb_ctrl_if #(.NUM_REQ(N)) bus ();

    regfile_wb_ctrl #(.NUM_REQ(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wb            (bus.slave),
        .wr_en_o       (wr_en),
        .rd_idx_o      (rd_idx),
        .rd_data_o     (rd_data),
        .alloc_valid_i (alloc_valid),
        .alloc_idx_i   (alloc_idx),
        .alloc_busy_o  (alloc_busy),
        .rs1_idx_i     (rs1_idx),
        .rs2_idx_i     (rs2_idx),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [31:0] m_busy;
    int        m_ptr;
    bit        m_wr;
    reg_idx_t  m_idx;
    xlen_t     m_data;
    bit        m_known = 1'b0;
    int        m_last_g = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int r;
            r = (m_ptr + k) % N;
            if (bus.req_valid_i[r]) return r;
        end
        return -1;
    endfunction

    function automatic bit model_busy(input reg_idx_t i);
        return (i != 0) && m_busy[i];
    endfunction

    task automatic drive_req(input int r, input bit v, input reg_idx_t idx, input xlen_t d);
        bus.req_valid_i[r] = v;
        bus.req_idx_i[r]   = idx;
        bus.req_data_i[r]  = d;
    endtask

    // One clock: check combinational outputs, step the model across the edge, check registers.
    task automatic cycle();
        int        g;
        logic [N-1:0] er;
        bit [31:0] nb;
        bit        s_rst, s_av;
        reg_idx_t  s_ai, g_idx;
        xlen_t     g_data;
        #1;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        g_idx  = (g >= 0) ? bus.req_idx_i[g]  : '0;
        g_data = (g >= 0) ? bus.req_data_i[g] : '0;
        s_rst = rst; s_av = alloc_valid; s_ai = alloc_idx;
        if (m_known) begin
            chk("ready",      32'(bus.req_ready_o), 32'(er));
            chk("alloc_busy", 32'(alloc_busy),      32'(model_busy(alloc_idx)));
            chk("rs1_busy",   32'(rs1_busy),        32'(model_busy(rs1_idx)));
            chk("rs2_busy",   32'(rs2_busy),        32'(model_busy(rs2_idx)));
        end
        @(posedge clk);
        if (s_rst) begin
            m_wr = 0; m_idx = '0; m_data = '0; m_ptr = 0; m_busy = '0;
            m_known = 1'b1;
        end else begin
            nb = m_busy;
            if (m_wr) nb[m_idx] = 1'b0;
            if (s_av && s_ai != 0) nb[s_ai] = 1'b1;
            if (g >= 0) begin
                m_ptr  = (g + 1) % N;
                m_wr   = (g_idx != 0);
                m_idx  = g_idx;
                m_data = g_data;
            end else begin
                m_wr = 1'b0;
            end
            m_busy = nb;
        end
        m_last_g = g;
        #1;
        if (m_known) begin
            chk("wr_en",   32'(wr_en),  32'(m_wr));
            chk("rd_idx",  32'(rd_idx), 32'(m_idx));
            chk("rd_data", rd_data,     m_data);
        end
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_idx_i   = '0;
        bus.req_data_i  = '0;
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        rs1_idx     = '0;
        rs2_idx     = '0;

        // Reset then idle
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        alloc_idx = 5'd7; rs1_idx = 5'd5; rs2_idx = 5'd9;
        #1;
        chk("rst_wr_en",   32'(wr_en),      32'd0);
        chk("rst_rd_idx",  32'(rd_idx),     32'd0);
        chk("rst_rd_data", rd_data,         32'd0);
        chk("rst_busy",    32'({alloc_busy, rs1_busy, rs2_busy}), 32'd0);

        // Single write
        alloc_valid = 1'b1; alloc_idx = 5'd5;
        cycle();
        alloc_valid = 1'b0;
        drive_req(0, 1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("sw_ready", 32'(bus.req_ready_o), 32'b01);
        chk("sw_busy_set", 32'(rs1_busy), 32'd1);
        cycle();
        drive_req(0, 0, 5'd0, 32'h0);
        chk("sw_wr_en", 32'(wr_en), 32'd1);
        chk("sw_idx", 32'(rd_idx), 32'd5);
        chk("sw_data", rd_data, 32'hDEADBEEF);
        #1;
        chk("sw_busy_until_commit", 32'(rs1_busy), 32'd1);
        cycle();
        chk("sw_busy_cleared", 32'(rs1_busy), 32'd0);

        // Contention from reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive_req(0, 1, 5'd3, 32'h11);
        drive_req(1, 1, 5'd4, 32'h22);
        #1;
        chk("ct_grant0", 32'(bus.req_ready_o), 32'b01);
        cycle();
        drive_req(0, 0, 5'd0, 32'h0);
        #1;
        chk("ct_grant1", 32'(bus.req_ready_o), 32'b10);
        chk("ct_wr0", 32'({wr_en, rd_idx}), 32'({1'b1, 5'd3}));
        cycle();
        drive_req(1, 0, 5'd0, 32'h0);
        chk("ct_wr1", 32'({wr_en, rd_idx}), 32'({1'b1, 5'd4}));
        drive_req(0, 1, 5'd3, 32'h33);
        drive_req(1, 1, 5'd4, 32'h44);
        #1;
        chk("ct_regrant0", 32'(bus.req_ready_o), 32'b01);
        cycle();
        drive_req(0, 0, 5'd0, 32'h0);
        #1;
        chk("ct_regrant1", 32'(bus.req_ready_o), 32'b10);
        cycle();
        drive_req(1, 0, 5'd0, 32'h0);
        chk("ct_data1", rd_data, 32'h44);

        // x0 handling
        drive_req(1, 1, 5'd0, 32'hFFFFFFFF);
        alloc_valid = 1'b1; alloc_idx = 5'd0; rs1_idx = 5'd0;
        #1;
        chk("x0_ready", 32'(bus.req_ready_o), 32'b10);
        cycle();
        drive_req(1, 0, 5'd0, 32'h0);
        alloc_valid = 1'b0;
        chk("x0_wr_en", 32'(wr_en), 32'd0);
        chk("x0_data", rd_data, 32'hFFFFFFFF);
        chk("x0_busy", 32'({alloc_busy, rs1_busy}), 32'd0);

        // Set/clear collision on idx 7
        alloc_valid = 1'b1; alloc_idx = 5'd7;
        cycle();
        alloc_valid = 1'b0;
        drive_req(0, 1, 5'd7, 32'h77);
        cycle();
        drive_req(0, 0, 5'd0, 32'h0);
        chk("col_wr", 32'({wr_en, rd_idx}), 32'({1'b1, 5'd7}));
        alloc_valid = 1'b1; alloc_idx = 5'd7;
        cycle();
        alloc_valid = 1'b0; rs1_idx = 5'd7;
        #1;
        chk("col_set_wins", 32'(rs1_busy), 32'd1);
        drive_req(1, 1, 5'd7, 32'h78);
        cycle();
        drive_req(1, 0, 5'd0, 32'h0);
        cycle();
        chk("col_cleared", 32'(rs1_busy), 32'd0);

        // Mid-operation reset with pointer moved off zero
        drive_req(0, 1, 5'd12, 32'h1200);
        alloc_valid = 1'b1; alloc_idx = 5'd2;
        cycle();
        drive_req(0, 0, 5'd0, 32'h0);
        alloc_idx = 5'd9;
        cycle();
        alloc_valid = 1'b0; rs1_idx = 5'd2; rs2_idx = 5'd9;
        #1;
        chk("mr_busy_pre", 32'({rs1_busy, rs2_busy}), 32'b11);
        drive_req(0, 1, 5'd2, 32'h2222);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive_req(0, 0, 5'd0, 32'h0);
        chk("mr_wr_en", 32'(wr_en), 32'd0);
        #1;
        chk("mr_busy_post", 32'({rs1_busy, rs2_busy}), 32'd0);
        drive_req(0, 1, 5'd20, 32'hA0);
        drive_req(1, 1, 5'd21, 32'hA1);
        #1;
        chk("mr_ptr_zero", 32'(bus.req_ready_o), 32'b01);
        cycle();
        drive_req(0, 0, 5'd0, 32'h0);
        cycle();
        drive_req(1, 0, 5'd0, 32'h0);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            reg_idx_t a;
            for (int r = 0; r < N; r++) begin
                if (!bus.req_valid_i[r] && $urandom_range(0, 2) == 0)
                    drive_req(r, 1, 5'($urandom_range(0, 31)), $urandom);
            end
            a = 5'($urandom_range(0, 31));
            alloc_idx   = a;
            alloc_valid = ($urandom_range(0, 3) == 0) && !model_busy(a);
            rs1_idx = 5'($urandom_range(0, 31));
            rs2_idx = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 63) == 0);
            cycle();
            for (int r = 0; r < N; r++) begin
                if (r == m_last_g) bus.req_valid_i[r] = 1'b0;
            end
        end
        rst = 1'b0;
        alloc_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
